// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and pointer-wrap helper for the synchronous flag FIFO.
package fifo_pkg;

   typedef enum logic [1:0] {OP_IDLE, OP_PUSH, OP_POP, OP_BOTH} fifo_op_e;

   function automatic int ptr_inc(input int ptr, input int depth);
      return (ptr == depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_sync_mem.sv
// fifo_sync_mem: FIFO storage array, synchronous write port, asynchronous read port.
module fifo_sync_mem #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             FIFO_clr_n,
   input  logic             we,
   input  logic [PTR_W-1:0] wr_ptr,
   input  logic [WIDTH-1:0] data_in,
   input  logic [PTR_W-1:0] rd_ptr,
   output logic [WIDTH-1:0] data_out
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge FIFO_clr_n)
      if (!FIFO_clr_n)
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      else if (we)
         mem[wr_ptr] <= data_in;

   assign data_out = mem[rd_ptr];

endmodule

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FWFT FIFO with full/empty, almost flags and sticky errors.
// Defining FIFO_WATERMARK_EN adds max_level, the peak occupancy since the last clear/flush.
module fifo_sync_flags
   import fifo_pkg::*;
#(
   parameter int FIFO_depth = 8,
   parameter int FIFO_width = 4,
   parameter int AF_THRESH  = 6,
   parameter int AE_THRESH  = 1,
   localparam int PTR_W = $clog2(FIFO_depth),
   localparam int CNT_W = $clog2(FIFO_depth + 1)
) (
   input  logic                  clk,
   input  logic                  FIFO_clr_n,
   input  logic                  FIFO_reset_n,
   input  logic [FIFO_width-1:0] data_in,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  err_clr,
   output logic [FIFO_width-1:0] data_out,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
`ifdef FIFO_WATERMARK_EN
   , output logic [CNT_W-1:0]    max_level
`endif
);

   localparam logic [CNT_W-1:0] FULL_C = CNT_W'(FIFO_depth);
   localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);
   localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_THRESH);

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count_nxt;
   logic             push_ok, pop_ok;
   fifo_op_e         op;

   assign full         = count == FULL_C;
   assign empty        = count == '0;
   assign almost_full  = count >= AF_C;
   assign almost_empty = count <= AE_C;

   // Full never coincides with empty (depth >= 2), so a push beside a pop at full is safe.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;
   assign op      = fifo_op_e'({pop_ok, push_ok});

   always_comb begin
      count_nxt = (op == OP_PUSH) ? count + 1'b1 :
                  (op == OP_POP)  ? count - 1'b1 : count;
   end

   always_ff @(posedge clk or negedge FIFO_clr_n)
      if (!FIFO_clr_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (!FIFO_reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= PTR_W'(ptr_inc(int'(wr_ptr), FIFO_depth));
         if (pop_ok) rd_ptr <= PTR_W'(ptr_inc(int'(rd_ptr), FIFO_depth));
         count     <= count_nxt;
         overflow  <= (overflow && !err_clr) || (push && !push_ok);
         underflow <= (underflow && !err_clr) || (pop && !pop_ok);
      end

`ifdef FIFO_WATERMARK_EN
   always_ff @(posedge clk or negedge FIFO_clr_n)
      if (!FIFO_clr_n)
         max_level <= '0;
      else if (!FIFO_reset_n)
         max_level <= '0;
      else if (count > max_level)
         max_level <= count;
`endif

   fifo_sync_mem #(.DEPTH(FIFO_depth), .WIDTH(FIFO_width), .PTR_W(PTR_W)) u_mem (
      .clk        (clk),
      .FIFO_clr_n (FIFO_clr_n),
      .we         (push_ok && FIFO_reset_n),
      .wr_ptr     (wr_ptr),
      .data_in    (data_in),
      .rd_ptr     (rd_ptr),
      .data_out   (data_out)
   );

endmodule
